// File: rtl/spike_rate_decoder_pkg.sv
// Shared constants for the spike rate decoder: widths and the hex seven-segment table.
package spike_rate_decoder_pkg;

  localparam int RATE_W = 4;
  localparam int WIN_W  = 24;

  // Segments g..a, active high, bit0 = a
  localparam logic [6:0] SEG7_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/spike_rate_decoder_seg7_hex.sv
// Combinational hex digit to seven-segment decode.
module seg7_hex
  import spike_rate_decoder_pkg::*;
(
  input  logic [RATE_W-1:0] hex,
  output logic [6:0]        seg
);

  assign seg = SEG7_TBL[hex];

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts rising edges of a neuron spike train over a fixed window of enabled
// cycles and latches the saturated count plus its seven-segment image.
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter logic [WIN_W-1:0] WINDOW_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              spike_in,
  output logic [7:0]        seg_out,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid
);

  localparam logic [WIN_W-1:0] WIN_LAST = WINDOW_CYCLES - 1'b1;

  function automatic logic [RATE_W-1:0] sat_inc(input logic [RATE_W-1:0] a,
                                                input logic              inc);
    if (inc && (&a))
      return a;
    return a + {{(RATE_W-1){1'b0}}, inc};
  endfunction

  logic              spike_q;
  logic              spike_evt;
  logic [WIN_W-1:0]  win_cnt;
  logic [RATE_W-1:0] acc;
  logic              ovf;
  logic              terminal;
  logic [RATE_W-1:0] rate_next;
  logic              dp_next;
  logic [6:0]        seg_next;

  // Edge detect and window bookkeeping (combinational view of the current cycle)
  assign spike_evt = spike_in & ~spike_q;
  assign terminal  = en && (win_cnt == WIN_LAST);
  assign rate_next = sat_inc(acc, spike_evt);
  assign dp_next   = ovf | (spike_evt & (&acc));

  seg7_hex u_seg7_hex (
    .hex (rate_next),
    .seg (seg_next)
  );

  // Registered state; outputs latch on the edge closing the terminal cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q    <= 1'b0;
      win_cnt    <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      seg_out    <= 8'h3F;
    end else begin
      spike_q    <= spike_in;
      rate_valid <= 1'b0;
      if (en) begin
        if (terminal) begin
          win_cnt    <= '0;
          acc        <= '0;
          ovf        <= 1'b0;
          rate       <= rate_next;
          seg_out    <= {dp_next, seg_next};
          rate_valid <= 1'b1;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          acc     <= sat_inc(acc, spike_evt);
          if (spike_evt && (&acc))
            ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter WINDOW_CYCLES, default 24'd10_000_000, is the length of the measurement window in clk cycles; legal range 2..2^24-1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  high = window counter and spike accumulator advance; low = both hold.
REQ-005 spike_in  input  1  spike train from the neuron; synchronous to clk, arbitrary pulse width.
REQ-006 seg_out  output  8  [6:0] = segments a..g of the latched rate, active high, bit0 = a; [7] = dp = overflow flag of the latched window.
REQ-007 rate  output  4  latched spike count of the last completed window, saturated.
REQ-008 rate_valid  output  1  one-cycle pulse when rate/seg_out update.

Function
REQ-009 Spike detection SHALL register spike_in into spike_q; a spike event is spike_in & ~spike_q, so a level held high for any number of cycles counts once.
REQ-010 spike_q SHALL update every cycle regardless of en.
REQ-011 Window counter win_cnt (24 bit) SHALL count 0..WINDOW_CYCLES-1 while en=1 and wrap to 0; terminal cycle = win_cnt == WINDOW_CYCLES-1 with en=1.
REQ-012 Accumulator acc (4 bit) SHALL increment on a spike event when en=1, saturating at 15; a sticky ovf bit SHALL set when an event arrives with acc==15.
REQ-013 On the terminal cycle, rate <= acc + event (saturating at 15), the dp bit <= ovf | (event & acc==15), rate_valid <= 1, and acc/ovf clear to 0.
REQ-014 A spike event on the terminal cycle SHALL be counted in the closing window, never the next one.
REQ-015 Latency: rate, seg_out and rate_valid SHALL change on the clock edge that ends the terminal cycle, i.e. visible one cycle after it; rate_valid is high for exactly one cycle.
REQ-016 With en=0, events are ignored, win_cnt/acc/ovf hold, rate_valid stays 0, and rate/seg_out hold.
REQ-017 seg_out[6:0] SHALL be a registered hex decode of the latched rate: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-018 seg_out SHALL change only together with rate; no combinational path from spike_in or en to any output.

Reset
REQ-019 While rst=1: win_cnt=0, acc=0, ovf=0, spike_q=0, rate=0, rate_valid=0, seg_out=8'h3F.
REQ-020 rst SHALL take priority over en and spike events; a partial window in progress SHALL be discarded, with no rate_valid.
REQ-021 The first window after reset release SHALL start at win_cnt=0 on the first cycle with rst=0 and en=1.

Structure
REQ-022 A shared package SHALL hold the 16-entry seven-segment constant table, the rate width (4), and the window counter width (24).
REQ-023 The hex-to-seven-segment decode SHALL be a sub-module seg7_hex (4-bit in, 7-bit out, combinational), registered in spike_rate_decoder.
REQ-024 The block SHALL instantiate downstream of the neuron top level, taking its spike output; it SHALL not modify the neuron.

Verification (WINDOW_CYCLES=16 unless stated)
REQ-025 Reset check: rst=1 for 3 cycles, then release with en=0 -> seg_out=3F, rate=0, rate_valid=0 held indefinitely.
REQ-026 Three 1-cycle spikes at win_cnt 2, 5, 9 with en=1 -> one cycle after win_cnt=15: rate=3, seg_out=4F, rate_valid pulse of width 1; next window with no spikes -> rate=0, seg_out=3F.
REQ-027 spike_in held high for 20 cycles across a window boundary -> counted once; a 1-cycle spike exactly at win_cnt=15 -> included in that window's rate.
REQ-028 17 spikes in one window (WINDOW_CYCLES=64, spikes every 2 cycles) -> rate=15, seg_out=F1 (dp set); following empty window -> seg_out=3F.
REQ-029 en dropped for 10 cycles mid-window while spikes toggle -> those spikes are ignored and the window end is delayed by exactly 10 cycles.
REQ-030 rst asserted at win_cnt=8 with acc=4 -> no rate_valid, outputs return to reset values, and the next window ends 16 enabled cycles after release.
